// File: rtl/spu_icache_if.sv
// spu_icache_if: fetch-side and local-store-side signals of the
// SPU instruction cache, with cache (slave) and environment (master) views.
interface spu_icache_if #(
  parameter int ADDR_W      = 15,
  parameter int FETCH_BYTES = 8,
  parameter int BEAT_BYTES  = 16,
  parameter int CNT_W       = 16
);
  logic                     fetch_req;
  logic [ADDR_W-1:0]        fetch_addr;
  logic                     fetch_ready;
  logic                     fetch_valid;
  logic [FETCH_BYTES*8-1:0] fetch_data;
  logic                     flush;
  logic                     ls_req_valid;
  logic [ADDR_W-1:0]        ls_req_addr;
  logic                     ls_req_ready;
  logic                     ls_rsp_valid;
  logic [BEAT_BYTES*8-1:0]  ls_rsp_data;
  logic                     miss_busy;
  logic [CNT_W-1:0]         hit_cnt;
  logic [CNT_W-1:0]         miss_cnt;

  modport slave (
    input  fetch_req, fetch_addr, flush,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output fetch_ready, fetch_valid, fetch_data,
    output ls_req_valid, ls_req_addr,
    output miss_busy, hit_cnt, miss_cnt
  );

  modport master (
    output fetch_req, fetch_addr, flush,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  fetch_ready, fetch_valid, fetch_data,
    input  ls_req_valid, ls_req_addr,
    input  miss_busy, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/spu_icache.sv
// spu_icache: direct-mapped SPU instruction cache in front of the
// local store, with multi-beat line refill, flush and perf counters.
module spu_icache #(
  parameter int ADDR_W      = 15,
  parameter int LINE_BYTES  = 128,
  parameter int NUM_LINES   = 4,
  parameter int FETCH_BYTES = 8,
  parameter int BEAT_BYTES  = 16,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         reset,
  spu_icache_if.slave  bus
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LB    = LINE_BYTES * 8;
  localparam int FB    = FETCH_BYTES * 8;
  localparam int BB    = BEAT_BYTES * 8;
  localparam int LBW   = $clog2(LB);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REQ, FILL, REPLAY
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [BW-1:0]        beat_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LB-1:0]        line_q [NUM_LINES];
  logic                 flushed_q;
  logic [CNT_W-1:0]     hit_q, miss_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [OFF_W-1:0] off_al;
  logic [LBW-1:0]   rd_lo, wr_lo;
  logic             hit, last_beat, fill_beat, lookup;
  logic             ready, fvalid, req_valid, busy;

  assign idx    = addr_q[OFF_W +: IDX_W];
  assign tag    = addr_q[ADDR_W-1 -: TAG_W];
  assign off_al = addr_q[OFF_W-1:0] & ~OFF_W'(FETCH_BYTES - 1);
  assign hit    = valid_q[idx] && (tag_q[idx] == tag);
  assign lookup = (state_q == LOOKUP);

  // byte 0 of a line sits in the MSBs, so offsets count down
  assign rd_lo = LBW'(8 * (LINE_BYTES - FETCH_BYTES - int'(off_al)));
  assign wr_lo = LBW'((BEATS - 1 - int'(beat_q)) * BB);

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign fill_beat = (state_q == FILL) && bus.ls_rsp_valid;

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    fvalid    = 1'b0;
    req_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.fetch_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          fvalid  = 1'b1;
          ready   = 1'b1;
          state_d = bus.fetch_req ? LOOKUP : IDLE;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        req_valid = 1'b1;
        busy      = 1'b1;
        if (bus.ls_req_ready) state_d = FILL;
      end
      FILL: begin
        busy = 1'b1;
        if (fill_beat && last_beat) state_d = REPLAY;
      end
      REPLAY: begin
        fvalid  = 1'b1;
        ready   = 1'b1;
        state_d = bus.fetch_req ? LOOKUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      beat_q    <= '0;
      valid_q   <= '0;
      flushed_q <= 1'b0;
      hit_q     <= '0;
      miss_q    <= '0;
    end else begin
      state_q <= state_d;
      if (bus.fetch_req && ready) addr_q <= bus.fetch_addr;
      if (lookup && hit && hit_q != '1)
        hit_q <= hit_q + CNT_W'(1);
      if (lookup && !hit && miss_q != '1)
        miss_q <= miss_q + CNT_W'(1);
      // a flush seen during the refill keeps the new line invalid
      if (lookup) flushed_q <= 1'b0;
      else if (bus.flush) flushed_q <= 1'b1;
      if (fill_beat) beat_q <= last_beat ? '0 : beat_q + BW'(1);
      if (bus.flush) valid_q <= '0;
      else if (fill_beat && last_beat && !flushed_q)
        valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_beat) begin
      line_q[idx][wr_lo +: BB] <= bus.ls_rsp_data;
      if (last_beat) tag_q[idx] <= tag;
    end
  end

  assign bus.fetch_ready  = ready;
  assign bus.fetch_valid  = fvalid;
  assign bus.fetch_data   = fvalid ? line_q[idx][rd_lo +: FB] : '0;
  assign bus.ls_req_valid = req_valid;
  assign bus.ls_req_addr  =
    req_valid ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
  assign bus.miss_busy    = busy;
  assign bus.hit_cnt      = hit_q;
  assign bus.miss_cnt     = miss_q;
endmodule
